// File: rtl/ysyx_25060170_pkg.sv
// +----------------------------------------------------------------------+
// | ysyx_25060170_pkg : shared constants and FSM encoding for the IFU     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ysyx_25060170_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_ifu_if.sv
// +----------------------------------------------------------------------+
// | ysyx_25060170_ifu_if : IFU memory, IDU and redirect signal bundle     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface ysyx_25060170_ifu_if
  import ysyx_25060170_pkg::*;
#(
  parameter int unsigned W = XLEN
);

  logic         ifu_req_valid;
  logic         ifu_req_ready;
  logic [W-1:0] ifu_req_addr;
  logic         ifu_rsp_valid;
  logic [W-1:0] ifu_rsp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst;
  logic [W-1:0] inst_pc;
  logic         redirect_valid;
  logic [W-1:0] jump_Addr;
  logic         ifu_misalign;

  modport master (
    output ifu_req_valid, ifu_req_addr, inst_valid, inst, inst_pc, ifu_misalign,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, inst_ready,
           redirect_valid, jump_Addr
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, inst_valid, inst, inst_pc, ifu_misalign,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, inst_ready,
           redirect_valid, jump_Addr
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_25060170_ifu.sv
// +----------------------------------------------------------------------+
// | ysyx_25060170_ifu : single-outstanding instruction fetch unit         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC
) (
  input  wire                  clk,
  input  wire                  rst_n,
  ysyx_25060170_ifu_if.master  bus
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misalign_q, misalign_d;

  // A redirect is accepted in every state except IDLE.
  logic w_redirect;
  assign w_redirect = bus.redirect_valid && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = w_redirect && bus.jump_Addr[1];

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (w_redirect) pc_d = bus.jump_Addr;
        if (bus.ifu_req_ready) begin
          state_d = S_WAIT;
          // The old address went out on this handshake; its response must be dropped.
          if (w_redirect) kill_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.ifu_rsp_valid) begin
          if (kill_q || w_redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (w_redirect) pc_d = bus.jump_Addr;
          end else begin
            inst_d    = bus.ifu_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end else if (w_redirect) begin
          pc_d   = bus.jump_Addr;
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          pc_d    = bus.jump_Addr;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC_P;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= RESET_PC_P;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.ifu_req_valid = (state_q == S_REQ);
  assign bus.ifu_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.ifu_misalign  = misalign_q;

endmodule

`default_nettype wire
